// File: rtl/data_mem_lanes_if.sv
// Bus between the MIPS datapath and the lane-addressed data memory.
// The datapath (master) drives the access; the memory (slave) answers
// combinationally with load data, readiness and access-fault flags.
interface data_mem_lanes_if;
    logic        we;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        misaligned;
    logic        out_of_range;

    modport master (
        output we, size, load_unsigned, addr, wdata,
        input  rdata, ready, misaligned, out_of_range
    );

    modport slave (
        input  we, size, load_unsigned, addr, wdata,
        output rdata, ready, misaligned, out_of_range
    );
endinterface

// File: rtl/data_mem_lanes.sv
// Data memory for the single-cycle MIPS datapath: byte/half/word stores with
// lane enables, sign/zero-extended sub-word loads, misalignment and range
// flags, and a clear sequencer that zeroes the array after reset.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_CLEAR | zeroing word r_cnt each cycle; loads return 0, stores dropped
// S_READY | array clean; normal load/store traffic
module data_mem_lanes #(
    parameter int DEPTH = 128,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input logic               i_clk,
    input logic               i_rst,
    data_mem_lanes_if.slave   bus
);
    typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t             r_state;
    logic               r_ready;
    logic [IDX_W-1:0]   r_cnt;
    logic [31:0]        r_mem [DEPTH];

    logic [IDX_W-1:0]   w_idx;
    logic [1:0]         w_lane;
    logic               w_misaligned;
    logic               w_oor;
    logic               w_valid;
    logic               w_clr_we;
    logic               w_st_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wd;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_rdata;

    assign w_idx  = bus.addr[IDX_W+1:2];
    assign w_lane = bus.addr[1:0];

    assign w_oor        = |bus.addr[31:IDX_W+2];
    assign w_misaligned = ((bus.size == SZ_HALF) && bus.addr[0])
                        | ((bus.size == SZ_WORD) && (bus.addr[1:0] != 2'b00))
                        | (bus.size == 2'b11);
    assign w_valid      = !w_misaligned && !w_oor;

    // A store during reset or clear is discarded; r_ready mirrors S_READY.
    assign w_clr_we = (r_state == S_CLEAR) && !i_rst;
    assign w_st_we  = r_ready && bus.we && w_valid && !i_rst;

    // Lane enables and lane-replicated store data for the addressed word.
    always_comb begin
        w_be = 4'b0000;
        w_wd = bus.wdata;
        case (bus.size)
            SZ_BYTE: begin
                w_be[w_lane] = 1'b1;
                w_wd         = {4{bus.wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be = bus.addr[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{bus.wdata[15:0]}};
            end
            SZ_WORD: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Clear sequencer: reset restarts the sweep from word 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_CLEAR;
            r_ready <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == IDX_W'(DEPTH - 1)) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_READY;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Array write port: clear zeroes a whole word, stores update enabled lanes.
    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_st_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
                end
            end
        end
    end

    assign w_word = r_mem[w_idx];
    assign w_half = bus.addr[1] ? w_word[31:16] : w_word[15:0];

    // Lane select for byte loads.
    always_comb begin
        w_byte = w_word[7:0];
        case (w_lane)
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    // Load path: extend the selected lane(s); zero while not ready or invalid.
    always_comb begin
        w_rdata = '0;
        if (r_ready && w_valid) begin
            case (bus.size)
                SZ_BYTE: w_rdata = {{24{w_byte[7] & !bus.load_unsigned}}, w_byte};
                SZ_HALF: w_rdata = {{16{w_half[15] & !bus.load_unsigned}}, w_half};
                SZ_WORD: w_rdata = w_word;
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.rdata        = w_rdata;
    assign bus.ready        = r_ready;
    assign bus.misaligned   = w_misaligned;
    assign bus.out_of_range = w_oor;
endmodule

// File: tb/tb_data_mem_lanes.sv
// Directed bench for data_mem_lanes: an 8-word instance for clear, lane and
// reset behaviour, and a 128-word instance for address-range handling.
module tb_data_mem_lanes;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    data_mem_lanes_if bus8();
    data_mem_lanes_if bus128();

    data_mem_lanes #(.DEPTH(8)) u_dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus8.slave)
    );

    data_mem_lanes #(.DEPTH(128)) u_dut128 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus128.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All stimulus changes land 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc8(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
        bus8.we            = we;
        bus8.size          = sz;
        bus8.load_unsigned = uns;
        bus8.addr          = a;
        bus8.wdata         = d;
        #1;
    endtask

    task automatic acc128(input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        bus128.we            = we;
        bus128.size          = sz;
        bus128.load_unsigned = 1'b0;
        bus128.addr          = a;
        bus128.wdata         = d;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        acc8(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        acc128(1'b0, 2'b10, 32'h0, 32'h0);

        // Reset and clear sequence on the 8-word instance
        tick();
        tick();
        chk("rst_ready", {31'b0, bus8.ready}, 32'd0);
        chk("rst_rdata", bus8.rdata, 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("clr_ready_e%0d", i), {31'b0, bus8.ready}, (i == 8) ? 32'd1 : 32'd0);
        end
        for (int w = 0; w < 8; w++) begin
            acc8(1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0);
            chk($sformatf("clr_word%0d", w), bus8.rdata, 32'h0);
        end

        // Word store, pre-edge value visible until the edge
        acc8(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        chk("sw_pre_edge", bus8.rdata, 32'h0);
        tick();
        acc8(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("lw_10", bus8.rdata, 32'hDEADBEEF);

        // Byte store takes only wdata[7:0]
        acc8(1'b1, 2'b00, 1'b0, 32'h13, 32'hAAAA557F);
        tick();
        acc8(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("lw_after_sb", bus8.rdata, 32'h7FADBEEF);
        acc8(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        chk("lb_11", bus8.rdata, 32'hFFFFFFBE);
        acc8(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        chk("lbu_11", bus8.rdata, 32'h000000BE);
        acc8(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        chk("lb_13", bus8.rdata, 32'h0000007F);
        acc8(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        chk("lh_12", bus8.rdata, 32'h00007FAD);
        acc8(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        chk("lh_10", bus8.rdata, 32'hFFFFBEEF);
        acc8(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        chk("lhu_10", bus8.rdata, 32'h0000BEEF);
        acc8(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
        chk("lw_uns_ignored", bus8.rdata, 32'h7FADBEEF);

        // Misaligned stores are dropped and read as zero
        acc8(1'b1, 2'b01, 1'b0, 32'h11, 32'h00001111);
        chk("sh_11_mis", {31'b0, bus8.misaligned}, 32'd1);
        chk("sh_11_rdata", bus8.rdata, 32'h0);
        tick();
        acc8(1'b1, 2'b10, 1'b0, 32'h12, 32'h22222222);
        chk("sw_12_mis", {31'b0, bus8.misaligned}, 32'd1);
        chk("sw_12_rdata", bus8.rdata, 32'h0);
        tick();
        acc8(1'b1, 2'b11, 1'b0, 32'h10, 32'h33333333);
        chk("size11_mis", {31'b0, bus8.misaligned}, 32'd1);
        tick();
        acc8(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("lw_10_aligned", {31'b0, bus8.misaligned}, 32'd0);
        chk("lw_after_mis", bus8.rdata, 32'h7FADBEEF);

        // Upper halfword store leaves the low lanes alone
        acc8(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF1234);
        chk("sh_16_aligned", {31'b0, bus8.misaligned}, 32'd0);
        tick();
        acc8(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        chk("lw_14", bus8.rdata, 32'h12340000);

        // Range boundary on the 8-word instance (32 bytes)
        acc8(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0);
        chk("oor8_1c", {31'b0, bus8.out_of_range}, 32'd0);
        acc8(1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111);
        chk("oor8_20", {31'b0, bus8.out_of_range}, 32'd1);
        chk("oor8_rdata", bus8.rdata, 32'h0);
        tick();
        acc8(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        chk("oor8_alias0", bus8.rdata, 32'h0);

        // Range handling on the 128-word instance
        for (int i = 0; i < 300 && !bus128.ready; i++) tick();
        chk("ready128", {31'b0, bus128.ready}, 32'd1);
        acc128(1'b1, 2'b10, 32'h200, 32'h55AA55AA);
        chk("oor128_200", {31'b0, bus128.out_of_range}, 32'd1);
        tick();
        acc128(1'b0, 2'b10, 32'h0, 32'h0);
        chk("oor128_alias0", bus128.rdata, 32'h0);
        acc128(1'b1, 2'b10, 32'h1FC, 32'hCAFEF00D);
        chk("oor128_1fc", {31'b0, bus128.out_of_range}, 32'd0);
        tick();
        acc128(1'b0, 2'b10, 32'h1FC, 32'h0);
        chk("lw128_1fc", bus128.rdata, 32'hCAFEF00D);
        acc128(1'b0, 2'b10, 32'h8000_0000, 32'h0);
        chk("oor128_msb", {31'b0, bus128.out_of_range}, 32'd1);

        // Fill the 8-word array back to back
        for (int w = 0; w < 8; w++) begin
            acc8(1'b1, 2'b10, 1'b0, 32'(w * 4), 32'h01010101 * 32'(w + 1));
            tick();
        end
        acc8(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        chk("fill_w0", bus8.rdata, 32'h01010101);
        acc8(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0);
        chk("fill_w7", bus8.rdata, 32'h08080808);

        // One-cycle reset with a store pending: ready drops
        rst = 1'b1;
        acc8(1'b1, 2'b10, 1'b0, 32'h8, 32'hFFFFFFFF);
        tick();
        rst = 1'b0;
        acc8(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        chk("rst_pulse_ready", {31'b0, bus8.ready}, 32'd0);
        chk("rst_pulse_rdata", bus8.rdata, 32'h0);
        tick();
        tick();
        tick();
        // cnt is now 3: restart the clear
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            acc8(1'b1, 2'b10, 1'b0, 32'h4, 32'hA5A5A5A5);
            tick();
            chk($sformatf("reclr_ready_e%0d", i), {31'b0, bus8.ready}, (i == 8) ? 32'd1 : 32'd0);
        end
        for (int w = 0; w < 8; w++) begin
            acc8(1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0);
            chk($sformatf("reclr_word%0d", w), bus8.rdata, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/data_mem_lanes.md
# data_mem_lanes

Parametrised data memory for the single-cycle MIPS datapath, replacing the word-only data memory. It supports byte, halfword and word stores with byte-lane enables, and sign- or zero-extended sub-word loads (lb/lbu/lh/lhu/lw). It flags misaligned and out-of-range accesses. A reset-driven clear sequencer zeroes the whole array and holds `ready` low until the array is clean. Reads stay combinational so the monocycle datapath timing is unchanged. Stores commit on the rising clock edge.

## Interface
- `DEPTH`, 128: number of 32-bit words; power of 2, minimum 4.
- `IDX_W`, $clog2(DEPTH): word-index width; derived, not overridden.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `WE` in 1: store enable, sampled at the rising edge.
- `size` in 2: access size; 00 byte, 01 half, 10 word, 11 illegal.
- `load_unsigned` in 1: 1 = zero-extend sub-word loads; 0 = sign-extend.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data; sub-word data is taken from the low bits.
- `rdata` out 32: load result, extended per `size`/`load_unsigned`.
- `ready` out 1: 1 once the clear sequence has completed.
- `misaligned` out 1: access violates the alignment rule for `size`.
- `out_of_range` out 1: `addr` >= 4*DEPTH.

## Operation
- Storage: DEPTH x 32-bit array, little-endian byte lanes. Word index = `addr[IDX_W+1:2]`; lane = `addr[1:0]`.
- Range: `out_of_range` = (`addr[31:IDX_W+2]` != 0). Combinational at all times, including during clear.
- Alignment: `misaligned` = (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | (size==11). Combinational at all times.
- An access is valid when `!misaligned & !out_of_range`.
- FSM states CLEAR and READY. `ready` = (state==READY), registered.
  - rst=1 at an edge: state<=CLEAR, cnt<=0. Any clear in progress restarts from 0.
  - CLEAR, rst=0: mem[cnt]<=0, cnt<=cnt+1. When cnt==DEPTH-1, state<=READY.
  - READY: stays until rst.
- Stores commit at an edge when READY & WE & valid:
  - byte: lane `addr[1:0]` <= wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0].
  - word: all lanes <= wdata.
  - Unwritten lanes are unchanged.
- Dropped stores: stores with WE=1 during CLEAR, while rst=1, or on an invalid access are discarded. Memory is untouched.
- Loads (combinational): when !ready or the access is invalid, rdata = 0. Otherwise:
  - byte: selected lane, extended from bit 7.
  - half: selected halfword, extended from bit 15.
  - word: full word.
  - Extension is sign (load_unsigned=0) or zero (load_unsigned=1); `load_unsigned` is ignored for word.
- No file I/O. Contents after clear are all zero.

## Timing
- Reset values: ready=0 and rdata=0 from the first edge with rst=1. Flags follow inputs at all times.
- Clear latency: the first edge with rst=0 writes word 0. The DEPTH-th such edge writes word DEPTH-1 and sets ready=1. The first store is accepted at the next edge (DEPTH+1 edges after rst falls).
- Read latency: 0 cycles; rdata is combinational from addr/size and array contents.
- Read during a same-cycle store to the same word: rdata shows the pre-edge value. The new value is visible after the edge.
- Back-to-back stores, one per cycle, with no stalls.

## Test plan
- Reset clear: DEPTH=8; rst high 2 cycles, then low. ready=0 for 8 edges, 1 after the 8th. Words 0..7 all read 0x00000000.
- Word store/load: sw 0xDEADBEEF @0x10, then lw @0x10 -> 0xDEADBEEF. Before the edge, lw @0x10 -> 0.
- Byte lanes: after the sw above:
  - sb 0x7F @0x13 -> lw @0x10 = 0x7FADBEEF.
  - lb @0x11 = 0xFFFFFFBE; lbu @0x11 = 0x000000BE.
  - lh @0x12 = 0x00007FAD.
- Misalignment: sh @0x11 or sw @0x12 with WE=1 -> misaligned=1, rdata=0, memory unchanged. size=11 -> misaligned=1.
- Range: DEPTH=128, sw @0x200 -> out_of_range=1, store dropped. Aliased word @0x000 unchanged.
- Reset mid-clear and mid-traffic:
  - Fill memory with stores.
  - Assert rst for 1 cycle -> ready=0 the next cycle.
  - Pulse rst again at clear cnt=3 -> clear restarts and ready rises DEPTH edges after the final rst fall.
  - Stores issued during clear are dropped; all words read 0.
